// File: rtl/alu_input_sequencer.sv
// Single-button operand sequencer for the board ALU: captures A, B, then opcode, then holds.
// Optional macro DEBOUNCE_EN inserts a per-button debouncer between synchronizer and edge detector.
//
// state | meaning
// S_A   | waiting to capture operand A
// S_B   | waiting to capture operand B
// S_OP  | waiting to capture opcode
// S_RUN | full operand set loaded, ALU result displayed
module alu_input_sequencer #(
  parameter int DATA_LENGTH     = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] switches,
  input  logic                   btn_next,
  input  logic                   btn_clear,
  output logic [DATA_LENGTH-1:0] A,
  output logic [DATA_LENGTH-1:0] B,
  output logic [5:0]             Op_code,
  output logic [1:0]             state,
  output logic                   result_valid
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_e;

  if (DATA_LENGTH < 6) begin : g_bad_width
    $error("alu_input_sequencer: DATA_LENGTH must be at least 6");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("alu_input_sequencer: DEBOUNCE_CYCLES must be at least 1");
  end

  // Bit 0 carries btn_next, bit 1 carries btn_clear through the whole conditioning path.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] level;
  logic [1:0] prev_q, ev_q, ev_d;

  assign btn_raw = {btn_clear, btn_next};

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]            filt_q, filt_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign ev_d = level & ~prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
      ev_q    <= ev_d;
    end
  end

  logic                   next_ev, clear_ev;
  state_e                 state_q, state_d;
  logic [DATA_LENGTH-1:0] a_q, a_d, b_q, b_d;
  logic [5:0]             op_q, op_d;
  logic                   valid_q, valid_d;

  assign next_ev  = ev_q[0];
  assign clear_ev = ev_q[1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (clear_ev) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else if (next_ev) begin
      unique case (state_q)
        S_A: begin
          a_d     = switches;
          state_d = S_B;
        end
        S_B: begin
          b_d     = switches;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = switches[5:0];
          valid_d = 1'b1;
          state_d = S_RUN;
        end
        S_RUN: begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign Op_code      = op_q;
  assign state        = state_q;
  assign result_valid = valid_q;

endmodule
